gelato_warp_fetch_arbiter: RTL and testbench
============================================

# gelato_warp_fetch_arbiter

Per-SM fetch arbiter that sits between the split table and the instruction fetch unit. It holds a PC, active bit, stall bit and instruction-buffer credit count for every warp. Each cycle it selects one eligible warp round-robin and presents a registered valid/ready fetch request. On acceptance it advances that warp's PC and consumes one credit; credits return as the instruction buffer drains.

## Interface
- NUM_WARPS, 8: warps tracked; power of two, ≥2
- PC_WIDTH, 32: PC width
- IBUF_DEPTH, 2: per-warp instruction-buffer slots, i.e. max credits; ≥1
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- pc_load_valid  in  1  split table (re)starts a warp
- pc_load_warp  in  $clog2(NUM_WARPS)  target warp
- pc_load_pc  in  PC_WIDTH  new PC
- kill_valid  in  1  deactivate warp (exit/join)
- kill_warp  in  $clog2(NUM_WARPS)  target warp
- stall_valid  in  1  decode saw control flow; hold warp until next pc_load
- stall_warp  in  $clog2(NUM_WARPS)  target warp
- credit_ret_valid  in  1  instruction buffer dequeued one entry
- credit_ret_warp  in  $clog2(NUM_WARPS)  owning warp
- fetch_valid  out  1  request valid (registered)
- fetch_ready  in  1  fetch unit accepts
- fetch_warp  out  $clog2(NUM_WARPS)  requesting warp (registered)
- fetch_pc  out  PC_WIDTH  fetch address (registered)
- idle  out  1  no warp active (registered)
- credit_err  out  1  sticky; credit returned to a warp already at IBUF_DEPTH

## Operation
- Per-warp state: active, stalled, pc[PC_WIDTH], credits[$clog2(IBUF_DEPTH+1)].
- Reset values: all inactive, unstalled, pc=0, credits=IBUF_DEPTH; rr_ptr=NUM_WARPS-1, so warp 0 wins first; fetch_valid=0, fetch_warp=0, fetch_pc=0, idle=1, credit_err=0.
- Eligible(w) = active & !stalled & credits>0 & !(fetch_valid & fetch_warp==w). A warp never has two outstanding requests.
- Grant: first eligible warp scanning rr_ptr+1, rr_ptr+2, …, mod NUM_WARPS. rr_ptr updates to the granted warp on handshake.
- Two-state FSM:
  - IDLE (fetch_valid=0): if any warp is eligible, register fetch_valid=1, fetch_warp=grant, fetch_pc=pc[grant]; go to REQ.
  - REQ: hold all outputs stable while !fetch_ready.
  - Handshake (fetch_valid&fetch_ready): credits[w]−1 and pc[w]+4, wrapping mod 2^PC_WIDTH. If another warp is eligible in the same cycle (excluding w), register it and stay in REQ (back-to-back). Otherwise go to IDLE.
- Per-warp update priority in the same cycle: kill > pc_load > stall > handshake PC increment.
  - pc_load sets active=1, stalled=0, pc=pc_load_pc; the +4 is dropped.
  - kill clears active and stalled; credits are untouched.
- An already-presented request is never withdrawn, even if its warp is killed, stalled or reloaded while waiting. Downstream discards it via decode tagging.
- Credit return and handshake on the same warp in the same cycle: net credit change 0.
- Credit return at IBUF_DEPTH: count saturates and credit_err is set.
- idle = no warp active, registered from next-state.
- rdy=0: no register changes, handshake ignored, outputs hold.

## Timing
- Warp becomes eligible at edge N: fetch_valid=1 after edge N+1.
- pc_load at edge N: the warp may be requested after edge N+1 at the earliest.
- Sustained throughput: 1 request/cycle when fetch_ready=1 and ≥2 eligible warps.
- A single eligible warp with credits: one request every 2 cycles, because of the self-exclusion rule.
- Reset is asynchronous: outputs reach reset values immediately, including mid-REQ with fetch_ready high.

## Test plan
- Reset, then pc_load warps 0..3 with PC 0x100·(w+1), fetch_ready=1: requests issue in order w0 0x100, w1 0x200, w2 0x300, w3 0x400, w0 0x104, … with no gaps.
- IBUF_DEPTH=2, only warp 2 active at 0x40, no credit returns: exactly 2 requests (0x40, 0x44), then fetch_valid=0. One credit_ret for w2: next request is 0x48.
- fetch_ready=0 for 5 cycles while w1 is presented, and pc_load/stall/kill to w1 are applied during that window: fetch_warp=1 and fetch_pc unchanged throughout. After acceptance, w1 follows the priority rules (kill wins: w1 never requested again).
- Same cycle: handshake on w0 at 0x200 plus pc_load w0=0x800: next w0 fetch_pc=0x800 and credits[w0]=IBUF_DEPTH−1. Handshake plus credit_ret on the same warp: credits unchanged.
- Stall_valid w3, then 10 cycles with no pc_load: w3 never requested while others rotate. pc_load w3=0x0 → w3 resumes at 0x0.
- PC 0xFFFF_FFFC accepted: next fetch_pc=0x0. Credit_ret to a full warp: credit_err=1 and sticky until rst. Assert rst mid-REQ: fetch_valid=0 and idle=1 immediately.

Source files
------------

// File: rtl/gelato_warp_fetch_arbiter.sv
// Per-SM warp fetch arbiter: per-warp PC / active / stall / credit state and a
// registered round-robin fetch request toward the instruction fetch unit.
module gelato_warp_fetch_arbiter #(
    parameter int NUM_WARPS  = 8,
    parameter int PC_WIDTH   = 32,
    parameter int IBUF_DEPTH = 2,
    localparam int WW = $clog2(NUM_WARPS),
    localparam int CW = $clog2(IBUF_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                pc_load_valid,
    input  logic [WW-1:0]       pc_load_warp,
    input  logic [PC_WIDTH-1:0] pc_load_pc,
    input  logic                kill_valid,
    input  logic [WW-1:0]       kill_warp,
    input  logic                stall_valid,
    input  logic [WW-1:0]       stall_warp,
    input  logic                credit_ret_valid,
    input  logic [WW-1:0]       credit_ret_warp,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [WW-1:0]       fetch_warp,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                idle,
    output logic                credit_err,
    output logic                state_dbg
);
    // Handshake: a request transfers on a rising edge where rdy, fetch_valid
    // and fetch_ready are all high. Once fetch_valid is high, fetch_warp and
    // fetch_pc hold unchanged until that edge; a request is never withdrawn.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(IBUF_DEPTH);

    state_t                state_q, state_d;
    logic                  fv_d;
    logic [WW-1:0]         fw_d;
    logic [PC_WIDTH-1:0]   fpc_d;
    logic [WW-1:0]         rr_q, rr_d;
    logic                  err_d;

    logic [NUM_WARPS-1:0]  active_q, active_d;
    logic [NUM_WARPS-1:0]  stalled_q, stalled_d;
    logic [PC_WIDTH-1:0]   pc_q [NUM_WARPS];
    logic [PC_WIDTH-1:0]   pc_d [NUM_WARPS];
    logic [CW-1:0]         cred_q [NUM_WARPS];
    logic [CW-1:0]         cred_d [NUM_WARPS];

    logic                  hs;
    logic [NUM_WARPS-1:0]  elig;
    logic [NUM_WARPS-1:0]  hs_vec;
    logic [NUM_WARPS-1:0]  ret_vec;
    logic                  grant_any;
    logic [WW-1:0]         grant_warp;
    logic [WW-1:0]         idx;

    assign hs        = rdy && fetch_valid && fetch_ready;
    assign state_dbg = (state_q == S_REQ);

    // The warp already on the request port is excluded, so it never holds two
    // outstanding requests.
    always_comb begin
        elig    = '0;
        hs_vec  = '0;
        ret_vec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            elig[w]    = active_q[w] && !stalled_q[w] && (cred_q[w] != '0) &&
                         !(fetch_valid && (fetch_warp == WW'(w)));
            hs_vec[w]  = hs && (fetch_warp == WW'(w));
            ret_vec[w] = credit_ret_valid && (credit_ret_warp == WW'(w));
        end
    end

    always_comb begin
        grant_any  = 1'b0;
        grant_warp = '0;
        idx        = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = rr_q + WW'(i);
            if (!grant_any && elig[idx]) begin
                grant_any  = 1'b1;
                grant_warp = idx;
            end
        end
    end

    // Per-warp update: kill beats pc_load beats stall beats the PC advance.
    always_comb begin
        active_d  = active_q;
        stalled_d = stalled_q;
        pc_d      = pc_q;
        cred_d    = cred_q;
        err_d     = credit_err;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (kill_valid && (kill_warp == WW'(w))) begin
                active_d[w]  = 1'b0;
                stalled_d[w] = 1'b0;
            end else if (pc_load_valid && (pc_load_warp == WW'(w))) begin
                active_d[w]  = 1'b1;
                stalled_d[w] = 1'b0;
                pc_d[w]      = pc_load_pc;
            end else if (stall_valid && (stall_warp == WW'(w))) begin
                stalled_d[w] = 1'b1;
            end else if (hs_vec[w]) begin
                pc_d[w] = pc_q[w] + PC_WIDTH'(4);
            end

            if (hs_vec[w] && !ret_vec[w]) begin
                cred_d[w] = cred_q[w] - CW'(1);
            end else if (ret_vec[w] && !hs_vec[w]) begin
                if (cred_q[w] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[w] = cred_q[w] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fv_d    = fetch_valid;
        fw_d    = fetch_warp;
        fpc_d   = fetch_pc;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_REQ;
                    fv_d    = 1'b1;
                    fw_d    = grant_warp;
                    fpc_d   = pc_q[grant_warp];
                end
            end
            S_REQ: begin
                if (fetch_ready) begin
                    rr_d = fetch_warp;
                    if (grant_any) begin
                        fw_d  = grant_warp;
                        fpc_d = pc_q[grant_warp];
                    end else begin
                        state_d = S_IDLE;
                        fv_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                fv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_valid <= 1'b0;
            fetch_warp  <= '0;
            fetch_pc    <= '0;
            rr_q        <= WW'(NUM_WARPS - 1);
            idle        <= 1'b1;
            credit_err  <= 1'b0;
            active_q    <= '0;
            stalled_q   <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]   <= '0;
                cred_q[w] <= CRED_MAX;
            end
        end else if (rdy) begin
            state_q     <= state_d;
            fetch_valid <= fv_d;
            fetch_warp  <= fw_d;
            fetch_pc    <= fpc_d;
            rr_q        <= rr_d;
            idle        <= ~|active_d;
            credit_err  <= err_d;
            active_q    <= active_d;
            stalled_q   <= stalled_d;
            pc_q        <= pc_d;
            cred_q      <= cred_d;
        end
    end

endmodule

// File: tb/tb_gelato_warp_fetch_arbiter.sv
// Bench for gelato_warp_fetch_arbiter: directed scenarios with fixed expected
// sequences plus a randomized run against a warp-level reference model.
module tb_gelato_warp_fetch_arbiter;
    localparam int NW    = 8;
    localparam int PCW   = 32;
    localparam int DEPTH = 2;
    localparam int WW    = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rdy = 1'b1;
    logic           pc_load_valid = 1'b0;
    logic [WW-1:0]  pc_load_warp = '0;
    logic [PCW-1:0] pc_load_pc = '0;
    logic           kill_valid = 1'b0;
    logic [WW-1:0]  kill_warp = '0;
    logic           stall_valid = 1'b0;
    logic [WW-1:0]  stall_warp = '0;
    logic           credit_ret_valid = 1'b0;
    logic [WW-1:0]  credit_ret_warp = '0;
    logic           fetch_ready = 1'b0;
    logic           fetch_valid;
    logic [WW-1:0]  fetch_warp;
    logic [PCW-1:0] fetch_pc;
    logic           idle;
    logic           credit_err;
    logic           state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit             m_active [NW];
    bit             m_stalled [NW];
    logic [PCW-1:0] m_pc [NW];
    int             m_cred [NW];
    int             m_rr;
    bit             m_fv;
    int             m_fw;
    logic [PCW-1:0] m_fpc;
    bit             m_idle;
    bit             m_err;

    gelato_warp_fetch_arbiter #(
        .NUM_WARPS(NW), .PC_WIDTH(PCW), .IBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_load_valid(pc_load_valid), .pc_load_warp(pc_load_warp), .pc_load_pc(pc_load_pc),
        .kill_valid(kill_valid), .kill_warp(kill_warp),
        .stall_valid(stall_valid), .stall_warp(stall_warp),
        .credit_ret_valid(credit_ret_valid), .credit_ret_warp(credit_ret_warp),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_warp(fetch_warp), .fetch_pc(fetch_pc),
        .idle(idle), .credit_err(credit_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_active[w] = 0; m_stalled[w] = 0; m_pc[w] = '0; m_cred[w] = DEPTH;
        end
        m_rr = NW - 1; m_fv = 0; m_fw = 0; m_fpc = '0; m_idle = 1; m_err = 0;
    endtask

    // One rising edge of the model, from the inputs currently driven.
    task automatic model_edge();
        int  g;
        int  hw;
        bit  hs;
        if (rst || !rdy) return;
        hs = m_fv && fetch_ready;
        hw = m_fw;
        g  = -1;
        for (int i = 1; i <= NW; i++) begin
            int w;
            w = (m_rr + i) % NW;
            if (g < 0 && m_active[w] && !m_stalled[w] && m_cred[w] > 0 && !(m_fv && m_fw == w))
                g = w;
        end
        if (!m_fv) begin
            if (g >= 0) begin m_fv = 1; m_fw = g; m_fpc = m_pc[g]; end
        end else if (hs) begin
            m_rr = hw;
            if (g >= 0) begin m_fw = g; m_fpc = m_pc[g]; end
            else m_fv = 0;
        end
        for (int w = 0; w < NW; w++) begin
            bit hsw;
            bit rtw;
            hsw = hs && (hw == w);
            rtw = credit_ret_valid && (int'(credit_ret_warp) == w);
            if (kill_valid && int'(kill_warp) == w) begin
                m_active[w] = 0; m_stalled[w] = 0;
            end else if (pc_load_valid && int'(pc_load_warp) == w) begin
                m_active[w] = 1; m_stalled[w] = 0; m_pc[w] = pc_load_pc;
            end else if (stall_valid && int'(stall_warp) == w) begin
                m_stalled[w] = 1;
            end else if (hsw) begin
                m_pc[w] = m_pc[w] + 32'd4;
            end
            if (hsw && !rtw) m_cred[w] = m_cred[w] - 1;
            else if (rtw && !hsw) begin
                if (m_cred[w] == DEPTH) m_err = 1;
                else m_cred[w] = m_cred[w] + 1;
            end
        end
        m_idle = 1;
        for (int w = 0; w < NW; w++) if (m_active[w]) m_idle = 0;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc_load_valid = 0; kill_valid = 0; stall_valid = 0; credit_ret_valid = 0; rdy = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        fetch_ready = 0;
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic load(input int w, input logic [PCW-1:0] pc);
        pc_load_valid = 1; pc_load_warp = WW'(w); pc_load_pc = pc;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({fetch_valid, idle, credit_err} !== 3'b010)
            $display("FAIL reset_flags: got v/idle/err=%b expected 010", {fetch_valid, idle, credit_err});
        else n_pass++;
        n_checks++;
        if ({fetch_warp, fetch_pc} !== 35'd0)
            $display("FAIL reset_req: got warp %0d pc %h expected 0/0", fetch_warp, fetch_pc);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [WW+PCW-1:0] exp_q[$];
        logic [WW+PCW-1:0] got_q[$];
        int gaps = 0;
        do_reset();
        fetch_ready = 1;
        for (int k = 0; k < DEPTH; k++)
            for (int w = 0; w < 4; w++) exp_q.push_back({WW'(w), 32'(256 * (w + 1) + 4 * k)});
        for (int c = 0; c < 16; c++) begin
            if (c < 4) load(c, 32'(256 * (c + 1))); else pc_load_valid = 0;
            tick();
            if (fetch_valid) got_q.push_back({fetch_warp, fetch_pc});
            else if (got_q.size() > 0 && got_q.size() < exp_q.size()) gaps++;
        end
        n_checks++;
        if (got_q.size() != exp_q.size() || gaps != 0)
            $display("FAIL rr_count: got %0d requests %0d gaps expected %0d requests 0 gaps",
                     got_q.size(), gaps, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL rr_seq[%0d]: got warp %0d pc %h expected warp %0d pc %h", i,
                         got_q[i][PCW+WW-1:PCW], got_q[i][PCW-1:0], exp_q[i][PCW+WW-1:PCW], exp_q[i][PCW-1:0]);
            else n_pass++;
        end
    endtask

    task automatic test_credits();
        logic [PCW-1:0] got_q[$];
        do_reset();
        fetch_ready = 1;
        load(2, 32'h40);
        tick();
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fetch_valid) got_q.push_back(fetch_pc);
        end
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'h40 || got_q[1] !== 32'h44)
            $display("FAIL credit_limit: got %0d requests (first %h) expected 2 at 40,44",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0);
        else n_pass++;
        got_q.delete();
        for (int c = 0; c < 6; c++) begin
            credit_ret_valid = (c == 0); credit_ret_warp = 3'd2;
            tick();
            if (fetch_valid) got_q.push_back(fetch_pc);
        end
        credit_ret_valid = 0;
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'h48 || credit_err !== 1'b0)
            $display("FAIL credit_return: got %0d requests (first %h) err %b expected 1 at 48 err 0",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0, credit_err);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        load(1, 32'h1000);
        tick();
        clear_inputs();
        tick();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) load(1, 32'h2000);
            if (c == 1) begin stall_valid = 1; stall_warp = 3'd1; end
            if (c == 2) begin kill_valid = 1; kill_warp = 3'd1; end
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_warp !== 3'd1 || fetch_pc !== 32'h1000)
                $display("FAIL hold[%0d]: got v %b warp %0d pc %h expected 1/1/00001000",
                         c, fetch_valid, fetch_warp, fetch_pc);
            else n_pass++;
        end
        clear_inputs();
        fetch_ready = 1;
        tick();
        begin
            int seen = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (fetch_valid) seen++;
            end
            n_checks++;
            if (seen != 0 || idle !== 1'b1)
                $display("FAIL kill_wins: got %0d requests idle %b expected 0 requests idle 1", seen, idle);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle();
        int seen;
        bit found;
        do_reset();
        fetch_ready = 1;
        load(0, 32'h200);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200)
            $display("FAIL same_first: got v %b pc %h expected 1/00000200", fetch_valid, fetch_pc);
        else n_pass++;
        load(0, 32'h800);
        tick();
        clear_inputs();
        found = 0;
        for (int c = 0; c < 4 && !found; c++) begin
            tick();
            if (fetch_valid) found = 1;
        end
        n_checks++;
        if (!found || fetch_warp !== 3'd0 || fetch_pc !== 32'h800)
            $display("FAIL load_over_inc: got found %b warp %0d pc %h expected 1/0/00000800",
                     found, fetch_warp, fetch_pc);
        else n_pass++;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (fetch_valid) seen++;
        end
        n_checks++;
        if (seen != 0)
            $display("FAIL load_credit: got %0d extra requests expected 0", seen);
        else n_pass++;

        do_reset();
        fetch_ready = 1;
        load(5, 32'h500);
        tick();
        clear_inputs();
        tick();
        credit_ret_valid = 1; credit_ret_warp = 3'd5;
        tick();
        clear_inputs();
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fetch_valid) seen++;
        end
        n_checks++;
        if (seen != DEPTH || credit_err !== 1'b0)
            $display("FAIL hs_plus_ret: got %0d requests err %b expected %0d err 0", seen, credit_err, DEPTH);
        else n_pass++;
    endtask

    task automatic test_stall();
        int cnt [NW];
        int total = 0;
        bit found = 0;
        do_reset();
        for (int w = 0; w < NW; w++) cnt[w] = 0;
        for (int w = 0; w < 4; w++) begin
            load(w, 32'(32'h1000 * (w + 1)));
            tick();
        end
        clear_inputs();
        stall_valid = 1; stall_warp = 3'd3;
        tick();
        clear_inputs();
        fetch_ready = 1;
        for (int c = 0; c < 12; c++) begin
            credit_ret_valid = fetch_valid; credit_ret_warp = fetch_warp;
            if (fetch_valid) begin cnt[fetch_warp]++; total++; end
            tick();
        end
        n_checks++;
        if (cnt[3] != 0 || total != 12 || cnt[0] == 0 || cnt[1] == 0 || cnt[2] == 0)
            $display("FAIL stall_skip: got w0..3 = %0d %0d %0d %0d of %0d expected w3=0, others>0, 12 total",
                     cnt[0], cnt[1], cnt[2], cnt[3], total);
        else n_pass++;
        load(3, 32'h0);
        for (int c = 0; c < 10 && !found; c++) begin
            credit_ret_valid = fetch_valid; credit_ret_warp = fetch_warp;
            tick();
            pc_load_valid = 0;
            if (fetch_valid && fetch_warp == 3'd3) found = 1;
        end
        clear_inputs();
        n_checks++;
        if (!found || fetch_pc !== 32'h0)
            $display("FAIL stall_resume: got found %b pc %h expected 1/00000000", found, fetch_pc);
        else n_pass++;
    endtask

    task automatic test_wrap_err();
        bit found = 0;
        do_reset();
        fetch_ready = 1;
        load(4, 32'hFFFF_FFFC);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_first: got v %b pc %h expected 1/fffffffc", fetch_valid, fetch_pc);
        else n_pass++;
        tick();
        for (int c = 0; c < 4 && !found; c++) begin
            tick();
            if (fetch_valid) found = 1;
        end
        n_checks++;
        if (!found || fetch_warp !== 3'd4 || fetch_pc !== 32'h0)
            $display("FAIL wrap_next: got found %b warp %0d pc %h expected 1/4/00000000", found, fetch_warp, fetch_pc);
        else n_pass++;
        n_checks++;
        if (credit_err !== 1'b0)
            $display("FAIL err_clear: got %b expected 0", credit_err);
        else n_pass++;
        credit_ret_valid = 1; credit_ret_warp = 3'd6;
        tick();
        clear_inputs();
        repeat (3) tick();
        n_checks++;
        if (credit_err !== 1'b1)
            $display("FAIL err_sticky: got %b expected 1", credit_err);
        else n_pass++;
        fetch_ready = 0;
        load(6, 32'h600);
        tick();
        clear_inputs();
        found = 0;
        for (int c = 0; c < 4 && !found; c++) begin
            tick();
            if (fetch_valid) found = 1;
        end
        fetch_ready = 1;
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        if (!found || fetch_valid !== 1'b0 || idle !== 1'b1 || credit_err !== 1'b0)
            $display("FAIL async_reset: got found %b v %b idle %b err %b expected 1/0/1/0",
                     found, fetch_valid, idle, credit_err);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_rdy();
        do_reset();
        load(1, 32'h700);
        tick();
        clear_inputs();
        tick();
        fetch_ready = 1;
        for (int c = 0; c < 3; c++) begin
            rdy = 0;
            load(2, 32'h900);
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_warp !== 3'd1 || fetch_pc !== 32'h700)
                $display("FAIL rdy_freeze[%0d]: got v %b warp %0d pc %h expected 1/1/00000700",
                         c, fetch_valid, fetch_warp, fetch_pc);
            else n_pass++;
        end
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_warp !== 3'd1 || fetch_pc !== 32'h704)
            $display("FAIL rdy_resume: got v %b warp %0d pc %h expected 1/1/00000704", fetch_valid, fetch_warp, fetch_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2+WW+PCW:0] exp_v;
        logic [2+WW+PCW:0] got_v;
        int bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy              = ($urandom_range(0, 9) != 0);
            pc_load_valid    = ($urandom_range(0, 5) == 0);
            pc_load_warp     = WW'($urandom_range(0, NW - 1));
            pc_load_pc       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            kill_valid       = ($urandom_range(0, 19) == 0);
            kill_warp        = WW'($urandom_range(0, NW - 1));
            stall_valid      = ($urandom_range(0, 9) == 0);
            stall_warp       = WW'($urandom_range(0, NW - 1));
            credit_ret_valid = ($urandom_range(0, 2) == 0);
            credit_ret_warp  = WW'($urandom_range(0, NW - 1));
            fetch_ready      = ($urandom_range(0, 9) < 7);
            tick();
            exp_v = {m_fv, m_idle, m_err, m_fv ? WW'(m_fw) : 3'd0, m_fv ? m_fpc : 32'd0};
            got_v = {fetch_valid, idle, credit_err, fetch_valid ? fetch_warp : 3'd0, fetch_valid ? fetch_pc : 32'd0};
            n_checks++;
            if (got_v !== exp_v) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got v/idle/err=%b warp %0d pc %h expected %b warp %0d pc %h", c,
                             got_v[2+WW+PCW:WW+PCW], got_v[WW+PCW-1:PCW], got_v[PCW-1:0],
                             exp_v[2+WW+PCW:WW+PCW], exp_v[WW+PCW-1:PCW], exp_v[PCW-1:0]);
            end else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credits();
        test_hold();
        test_same_cycle();
        test_stall();
        test_wrap_err();
        test_rdy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
